// File: rtl/dr_pkg.sv
// Shared encodings, sizes and FSM states for the 10-channel dual-rail sync bridge.
// Optional illegal-code checking in the top is enabled by DR10_ILLEGAL_CHECK_EN.
package dr_pkg;

    localparam int DR_CHANNELS = 10;
    localparam int DR_WIDTH    = 2 * DR_CHANNELS;

    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        WAIT_NULL = 2'd0,
        WAIT_DATA = 2'd1,
        HOLD      = 2'd2
    } dr_state_e;

    // Binary value of a complete word is its set of true rails.
    function automatic logic [DR_CHANNELS-1:0] dr_decode(input logic [DR_WIDTH-1:0] bus);
        logic [DR_CHANNELS-1:0] word;
        for (int i = 0; i < DR_CHANNELS; i++) begin
            word[i] = bus[2*i+1];
        end
        return word;
    endfunction

endpackage

// File: rtl/dr_stable_detect.sv
// Second synchronizer stage plus stability counter; classifies the synchronized
// dual-rail word as complete, null or illegal once it has been steady long enough.
module dr_stable_detect
    import dr_pkg::*;
#(
    parameter int STABLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DR_WIDTH-1:0] sample,
    output logic [DR_WIDTH-1:0] sync_q,
    output logic                complete_stable,
    output logic                null_stable,
    output logic                illegal
);

    localparam logic [2:0] STABLE_LIM = 3'(STABLE_CYC);

    logic [DR_WIDTH-1:0] sync_q_r;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_next_s;
    logic                complete_s;
    logic                null_s;
    logic                illegal_s;

    // Second synchronizer flop; left unreset so a word held across reset never looks like NULL.
    always_ff @(posedge clk) begin
        sync_q_r <= sample;
    end

    // Saturating count of consecutive cycles in which the sample did not change.
    always_comb begin
        cnt_next_s = 3'd0;
        if (sample == sync_q_r) begin
            if (cnt_r == STABLE_LIM) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + 3'd1;
            end
        end else begin
            cnt_next_s = 3'd0;
        end
    end

    // Stability counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 3'd0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // Per-channel classification of the synchronized word.
    always_comb begin
        complete_s = 1'b1;
        null_s     = 1'b1;
        illegal_s  = 1'b0;
        for (int i = 0; i < DR_CHANNELS; i++) begin
            if ((sync_q_r[2*i +: 2] != DR_ZERO) && (sync_q_r[2*i +: 2] != DR_ONE)) begin
                complete_s = 1'b0;
            end else begin
                complete_s = complete_s;
            end
            if (sync_q_r[2*i +: 2] != DR_NULL) begin
                null_s = 1'b0;
            end else begin
                null_s = null_s;
            end
            if (sync_q_r[2*i +: 2] == DR_ILLEGAL) begin
                illegal_s = 1'b1;
            end else begin
                illegal_s = illegal_s;
            end
        end
    end

    assign sync_q          = sync_q_r;
    assign complete_stable = complete_s && (cnt_next_s == STABLE_LIM);
    assign null_stable     = null_s && (cnt_next_s == STABLE_LIM);
    assign illegal         = illegal_s;

endmodule

// File: rtl/dr10_sync_bridge.sv
// Dual-rail to clocked bridge: 4-phase acknowledge FSM and 2-entry output FIFO.
// Define DR10_ILLEGAL_CHECK_EN to latch a sticky err on any 2'b11 channel.
module dr10_sync_bridge
    import dr_pkg::*;
#(
    parameter int STABLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DR_WIDTH-1:0]    dr_in,
    output logic                   ack,
    output logic [DR_CHANNELS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err
);

    logic [DR_WIDTH-1:0]    sync1_r;
    logic [DR_WIDTH-1:0]    sync_q_s;
    logic                   complete_stable_s;
    logic                   null_stable_s;
    logic                   illegal_s;
    dr_state_e              state_r, state_next_s;
    logic                   push_s, pop_s, full_s;
    logic [1:0]             count_r, count_next_s;
    logic [DR_CHANNELS-1:0] head_r, head_next_s, tail_r, tail_next_s;
    logic [DR_CHANNELS-1:0] word_s;
    logic                   ack_r, out_valid_r, err_r;

    // First synchronizer flop.
    always_ff @(posedge clk) begin
        sync1_r <= dr_in;
    end

    dr_stable_detect #(.STABLE_CYC(STABLE_CYC)) u_detect (
        .clk             (clk),
        .rst             (rst),
        .sample          (sync1_r),
        .sync_q          (sync_q_s),
        .complete_stable (complete_stable_s),
        .null_stable     (null_stable_s),
        .illegal         (illegal_s)
    );

    assign word_s = dr_decode(sync_q_s);
    assign full_s = (count_r == 2'd2);
    assign pop_s  = out_valid_r && out_ready;

    // Handshake FSM next state; a full FIFO stalls in WAIT_DATA to backpressure the producer.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        case (state_r)
            WAIT_NULL: begin
                if (null_stable_s) state_next_s = WAIT_DATA;
                else               state_next_s = WAIT_NULL;
            end
            WAIT_DATA: begin
                if (complete_stable_s && !full_s) begin
                    push_s       = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = WAIT_DATA;
                end
            end
            HOLD: begin
                if (null_stable_s) state_next_s = WAIT_NULL;
                else               state_next_s = HOLD;
            end
            default: state_next_s = WAIT_NULL;
        endcase
    end

    // FIFO next state as a head/tail pair so the head register drives out_data directly.
    always_comb begin
        count_next_s = count_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) head_next_s = word_s;
                else                 tail_next_s = word_s;
                count_next_s = count_r + 2'd1;
            end
            2'b01: begin
                head_next_s  = tail_r;
                count_next_s = count_r - 2'd1;
            end
            2'b11: begin
                if (count_r == 2'd1) begin
                    head_next_s = word_s;
                end else begin
                    head_next_s = tail_r;
                    tail_next_s = word_s;
                end
            end
            default: count_next_s = count_r;
        endcase
    end

    // State, FIFO and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WAIT_NULL;
            count_r     <= 2'd0;
            head_r      <= '0;
            tail_r      <= '0;
            ack_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            ack_r       <= (state_next_s == HOLD);
            out_valid_r <= (count_next_s != 2'd0);
        end
    end

`ifdef DR10_ILLEGAL_CHECK_EN
    // Sticky illegal-code flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) err_r <= 1'b0;
        else     err_r <= err_r | illegal_s;
    end
`else
    // Illegal checking disabled: flag held low.
    always_ff @(posedge clk) begin
        err_r <= 1'b0;
    end
`endif

    assign ack       = ack_r;
    assign out_data  = head_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule
